// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(15,11) fault-injection campaign.
//   N_BITS       codeword length
//   K_BITS       data word length
//   N_ENSAIOS    trials per campaign (1 clean + 15 single-bit errors)
//   POS_SEM_ERRO position code that stands for the clean trial
//   estado_t     campaign sequencer states
package hamming_pkg;

  localparam int N_BITS    = 15;
  localparam int K_BITS    = 11;
  localparam int N_ENSAIOS = 16;
  localparam logic [3:0] POS_SEM_ERRO = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    APLICA,
    VERIFICA,
    FIM
  } estado_t;

endpackage

// File: rtl/hamming_campanha.sv
// Fault-injection campaign sequencer for the Hamming(15,11) datapath.
// One accepted start request runs 16 trials against encoder -> injector ->
// decoder: a clean trial, then one single-bit error at each codeword position
// 0..14. Each trial holds erro/n for LATENCIA cycles, then compares dado_dec
// with the latched word for one cycle. Failed trials are counted in falhas.
//
// Optional logging is enabled by defining HAMMING_CAMPANHA_LOG_EN, which adds
// primeira_falha (position of the first failing trial, 15 for the clean trial).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   inicio, dado    start pulse (sampled in IDLE only) and word under test
//   ocupado, fim    campaign in progress, one-cycle completion pulse
//   falhas          failed-trial count (0..16)
//   aprovado        falhas==0, valid from fim until the next accepted inicio
//   dado_enc        latched word sent to the encoder
//   erro, n         injector enable and bit position
//   dado_dec        decoder output
//   primeira_falha  (log build only) first failing position
//
// State table:
//   IDLE     | waiting for inicio, results held
//   APLICA   | trial controls driven, waiting LATENCIA cycles
//   VERIFICA | compare decoder output, advance trial
//   FIM      | fim pulse, return to IDLE
module hamming_campanha
  import hamming_pkg::*;
#(
  parameter int LATENCIA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inicio,
  input  logic [K_BITS-1:0] dado,
  output logic              ocupado,
  output logic              fim,
  output logic [4:0]        falhas,
  output logic              aprovado,
  output logic [K_BITS-1:0] dado_enc,
  output logic              erro,
  output logic [3:0]        n,
  input  logic [K_BITS-1:0] dado_dec
`ifdef HAMMING_CAMPANHA_LOG_EN
  ,
  output logic [3:0]        primeira_falha
`endif
);

  if (LATENCIA < 1 || LATENCIA > 15) begin : g_latencia_invalida
    $error("hamming_campanha: LATENCIA must be in 1..15");
  end

  localparam logic [3:0] ESPERA_INI = 4'(LATENCIA - 1);
  localparam logic [3:0] ULTIMO     = 4'(N_ENSAIOS - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] ensaio_q;
  logic [3:0] espera_q;
  logic       falha;

`ifdef HAMMING_CAMPANHA_LOG_EN
  logic [0:0] primeira_valida;
`endif

  assign falha = (dado_dec != dado_enc);

  always_comb begin
    estado_d = estado_q;
    ocupado  = 1'b0;
    fim      = 1'b0;
    case (estado_q)
      IDLE: begin
        if (inicio) estado_d = APLICA;
      end
      APLICA: begin
        ocupado = 1'b1;
        if (espera_q == 4'd0) estado_d = VERIFICA;
      end
      VERIFICA: begin
        ocupado  = 1'b1;
        estado_d = (ensaio_q == ULTIMO) ? FIM : APLICA;
      end
      FIM: begin
        fim      = 1'b1;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= IDLE;
      ensaio_q <= '0;
      espera_q <= '0;
      dado_enc <= '0;
      falhas   <= '0;
      aprovado <= 1'b0;
      erro     <= 1'b0;
      n        <= '0;
`ifdef HAMMING_CAMPANHA_LOG_EN
      primeira_falha  <= '0;
      primeira_valida <= '0;
`endif
    end else begin
      estado_q <= estado_d;
      case (estado_q)
        IDLE: begin
          if (inicio) begin
            dado_enc <= dado;
            falhas   <= '0;
            aprovado <= 1'b0;
            ensaio_q <= '0;
            espera_q <= ESPERA_INI;
            erro     <= 1'b0;
            n        <= '0;
`ifdef HAMMING_CAMPANHA_LOG_EN
            primeira_falha  <= '0;
            primeira_valida <= '0;
`endif
          end
        end
        APLICA: begin
          if (espera_q != 4'd0) espera_q <= espera_q - 4'd1;
        end
        VERIFICA: begin
          if (falha) falhas <= falhas + 5'd1;
`ifdef HAMMING_CAMPANHA_LOG_EN
          if (falha && !primeira_valida[0]) begin
            primeira_falha  <= (ensaio_q == 4'd0) ? POS_SEM_ERRO : n;
            primeira_valida <= 1'b1;
          end
`endif
          if (ensaio_q == ULTIMO) begin
            // Verdict must already be valid while fim is high, so it is
            // formed from the count including this last comparison.
            aprovado <= (falhas == 5'd0) && !falha;
            erro     <= 1'b0;
            n        <= '0;
          end else begin
            // Trial t+1 injects at codeword position t.
            ensaio_q <= ensaio_q + 4'd1;
            espera_q <= ESPERA_INI;
            erro     <= 1'b1;
            n        <= ensaio_q;
          end
        end
        FIM: begin
          erro <= 1'b0;
          n    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
